// File: rtl/rmii_pkg.sv
// Shared types and constants for the RMII receive path.
// Receiver FSM states, preamble/SFD dibits and the FIFO beat layout.
package rmii_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_DATA,
    S_DROP,
    S_TAIL
  } rx_state_t;

  localparam logic [1:0] RMII_PREAMBLE_DIBIT = 2'b01;
  localparam logic [1:0] RMII_SFD_DIBIT      = 2'b11;

  typedef struct packed {
    logic       user;
    logic       last;
    logic [7:0] data;
  } beat_t;

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock FIFO with a registered AXI-Stream style output stage.
// The output register counts as one of the DEPTH entries.
module axis_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_full,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_ready
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      mem_count;
  logic [AW:0]      total;
  logic             pop;
  logic             wr_accept;
  logic             load;
  logic             from_mem;
  logic             bypass;
  logic             to_mem;

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign pop       = rd_valid && rd_ready;
  assign total     = mem_count + {{AW{1'b0}}, rd_valid};
  assign wr_full   = (total == (AW+1)'(DEPTH)) && !pop;
  assign wr_accept = wr_en && !wr_full;
  assign load      = !rd_valid || pop;
  assign from_mem  = load && (mem_count != '0);
  assign bypass    = load && (mem_count == '0) && wr_accept;
  assign to_mem    = wr_accept && !bypass;

  always_ff @(posedge clock) begin
    if (to_mem) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_count <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      if (to_mem) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (from_mem) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + AW'(1);
      end else if (bypass) begin
        rd_data <= wr_data;
      end
      if (load) begin
        rd_valid <= from_mem || bypass;
      end
      mem_count <= mem_count + {{AW{1'b0}}, to_mem} - {{AW{1'b0}}, from_mem};
    end
  end

endmodule

// File: rtl/rmii_to_axis.sv
// RMII receive deserializer: strips preamble/SFD, builds LSB-first bytes
// and emits each frame as an AXI-Stream packet through a small FIFO.
module rmii_to_axis
  import rmii_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] rmii_d,
  input  logic       rmii_crs_dv,
  input  logic       rmii_er,
  output logic [7:0] maxis_tdata,
  output logic       maxis_tvalid,
  input  logic       maxis_tready,
  output logic       maxis_tlast,
  output logic       maxis_tuser,
  output logic       overflow
);

  rx_state_t  state_reg, state_next;
  logic [1:0] phase_reg, phase_next;
  logic [5:0] shift_reg, shift_next;
  logic [7:0] hold_reg, hold_next;
  logic       held_reg, held_next;
  logic       err_reg, err_next;
  logic       low_prev_reg, low_prev_next;
  logic       tail_done_reg, tail_done_next;
  logic       overflow_reg, overflow_next;

  logic       frame_end;
  logic       err_now;
  logic [7:0] byte_now;
  logic       push_en;
  beat_t      push_beat;
  beat_t      out_beat;
  logic       fifo_full;

  // A frame ends on a low crs_dv at a byte boundary, or on two lows in a row.
  assign frame_end = !rmii_crs_dv && ((phase_reg == 2'd0) || low_prev_reg);
  assign err_now   = err_reg || rmii_er;
  assign byte_now  = {rmii_d, shift_reg};

  always_comb begin
    state_next     = state_reg;
    phase_next     = phase_reg;
    shift_next     = shift_reg;
    hold_next      = hold_reg;
    held_next      = held_reg;
    err_next       = err_reg;
    low_prev_next  = !rmii_crs_dv;
    tail_done_next = tail_done_reg;
    overflow_next  = 1'b0;
    push_en        = 1'b0;
    push_beat      = '0;

    unique case (state_reg)
      S_IDLE: begin
        if (rmii_crs_dv) begin
          state_next = S_PREAMBLE;
        end
      end

      S_PREAMBLE: begin
        if (rmii_crs_dv && rmii_d == RMII_SFD_DIBIT) begin
          state_next = S_DATA;
          phase_next = 2'd0;
          err_next   = 1'b0;
          held_next  = 1'b0;
        end else if (!rmii_crs_dv && low_prev_reg) begin
          state_next = S_IDLE;
        end
      end

      S_DATA: begin
        if (frame_end) begin
          state_next = S_IDLE;
          phase_next = 2'd0;
          held_next  = 1'b0;
          if (held_reg) begin
            push_en   = 1'b1;
            push_beat = '{user: err_now || (phase_reg != 2'd0), last: 1'b1, data: hold_reg};
            // The terminating beat itself was lost: the tail beat closes the packet.
            if (fifo_full) begin
              overflow_next  = 1'b1;
              state_next     = S_TAIL;
              tail_done_next = 1'b0;
            end
          end
        end else begin
          err_next   = err_now;
          phase_next = phase_reg + 2'd1;
          unique case (phase_reg)
            2'd0: shift_next[1:0] = rmii_d;
            2'd1: shift_next[3:2] = rmii_d;
            2'd2: shift_next[5:4] = rmii_d;
            default: begin
              hold_next = byte_now;
              held_next = 1'b1;
              if (held_reg) begin
                push_en   = 1'b1;
                push_beat = '{user: 1'b0, last: 1'b0, data: hold_reg};
                if (fifo_full) begin
                  overflow_next = 1'b1;
                  held_next     = 1'b0;
                  state_next    = S_DROP;
                end
              end
            end
          endcase
        end
      end

      S_DROP: begin
        if (frame_end) begin
          state_next     = S_TAIL;
          phase_next     = 2'd0;
          tail_done_next = 1'b0;
        end else begin
          phase_next = phase_reg + 2'd1;
        end
      end

      S_TAIL: begin
        if (!tail_done_reg) begin
          push_en   = 1'b1;
          push_beat = '{user: 1'b1, last: 1'b1, data: 8'h00};
          if (!fifo_full) begin
            tail_done_next = 1'b1;
            if (!rmii_crs_dv) begin
              state_next = S_IDLE;
            end
          end
        end else if (!rmii_crs_dv) begin
          state_next = S_IDLE;
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      phase_reg     <= 2'd0;
      shift_reg     <= '0;
      hold_reg      <= '0;
      held_reg      <= 1'b0;
      err_reg       <= 1'b0;
      low_prev_reg  <= 1'b0;
      tail_done_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      phase_reg     <= phase_next;
      shift_reg     <= shift_next;
      hold_reg      <= hold_next;
      held_reg      <= held_next;
      err_reg       <= err_next;
      low_prev_reg  <= low_prev_next;
      tail_done_reg <= tail_done_next;
      overflow_reg  <= overflow_next;
    end
  end

  axis_sync_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(10)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (push_en),
    .wr_data (push_beat),
    .wr_full (fifo_full),
    .rd_data (out_beat),
    .rd_valid(maxis_tvalid),
    .rd_ready(maxis_tready)
  );

  assign maxis_tdata = out_beat.data;
  assign maxis_tlast = out_beat.last;
  assign maxis_tuser = out_beat.user;
  assign overflow    = overflow_reg;

endmodule

// File: tb/tb_rmii_to_axis.sv
// Self-checking bench for rmii_to_axis: directed frames plus randomized frames
// compared against a frame-level model of the expected AXI-Stream beats.
module tb_rmii_to_axis;
  import rmii_pkg::*;

  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] rmii_d = 2'b00;
  logic       rmii_crs_dv = 1'b0;
  logic       rmii_er = 1'b0;
  logic [7:0] maxis_tdata;
  logic       maxis_tvalid;
  logic       maxis_tready = 1'b0;
  logic       maxis_tlast;
  logic       maxis_tuser;
  logic       overflow;

  rmii_to_axis #(.FIFO_DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .rmii_d      (rmii_d),
    .rmii_crs_dv (rmii_crs_dv),
    .rmii_er     (rmii_er),
    .maxis_tdata (maxis_tdata),
    .maxis_tvalid(maxis_tvalid),
    .maxis_tready(maxis_tready),
    .maxis_tlast (maxis_tlast),
    .maxis_tuser (maxis_tuser),
    .overflow    (overflow)
  );

  always #10 clock = ~clock;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
  } beat_s;

  beat_s exp_q[$];
  beat_s got_q[$];
  int    checks = 0;
  int    errors = 0;
  int    ovf_pulses = 0;
  int    hold_violations = 0;
  int    ready_mode = 0;  // 0: tready low, 1: high, 2: random
  logic  prev_stall = 1'b0;
  logic [9:0] prev_beat = '0;

  // Observe on the falling edge, where all DUT outputs and tready are settled.
  always @(negedge clock) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!maxis_tvalid || {maxis_tdata, maxis_tlast, maxis_tuser} != prev_beat))
        hold_violations++;
      if (maxis_tvalid && maxis_tready)
        got_q.push_back('{data: maxis_tdata, last: maxis_tlast, user: maxis_tuser});
      if (overflow)
        ovf_pulses++;
      prev_stall = maxis_tvalid && !maxis_tready;
      prev_beat  = {maxis_tdata, maxis_tlast, maxis_tuser};
    end
  end

  task automatic drive(input logic crs, input logic [1:0] d, input logic er);
    rmii_crs_dv = crs;
    rmii_d      = d;
    rmii_er     = er;
    case (ready_mode)
      0:       maxis_tready = 1'b0;
      1:       maxis_tready = 1'b1;
      default: maxis_tready = ($urandom_range(0, 3) != 0);
    endcase
    @(posedge clock);
    #1;
  endtask

  // One frame on the wire: preamble, SFD, data, k trailing dibits, then idle gap.
  task automatic send_frame(input logic [7:0] bytes[$], input int er_idx, input int k,
                            input int toggle_pos, input int gap);
    logic [7:0] b;
    for (int i = 0; i < 28; i++) drive(1'b1, RMII_PREAMBLE_DIBIT, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, RMII_PREAMBLE_DIBIT, 1'b0);
    drive(1'b1, RMII_SFD_DIBIT, 1'b0);
    for (int i = 0; i < bytes.size(); i++) begin
      b = bytes[i];
      for (int p = 0; p < 4; p++)
        drive((i * 4 + p) != toggle_pos, b[2*p +: 2], (i == er_idx) && (p == 1));
    end
    for (int j = 0; j < k; j++) drive(1'b1, 2'($urandom_range(0, 3)), 1'b0);
    for (int j = 0; j < gap; j++) drive(1'b0, 2'b00, 1'b0);
  endtask

  // Frame-level expectation: every byte in order, last on the final one,
  // user there when the frame saw RX_ER or ended off a byte boundary.
  task automatic model_frame(input logic [7:0] bytes[$], input bit had_er, input int k);
    for (int i = 0; i < bytes.size(); i++)
      exp_q.push_back('{data: bytes[i], last: (i == bytes.size() - 1),
                        user: (i == bytes.size() - 1) && (had_er || k != 0)});
  endtask

  task automatic wait_beats(input int n, output bit timed_out);
    int cyc = 0;
    while (got_q.size() < n && cyc < 3000) begin
      drive(1'b0, 2'b00, 1'b0);
      cyc++;
    end
    timed_out = (got_q.size() < n);
    repeat (20) drive(1'b0, 2'b00, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ready_mode = 0;
    repeat (3) drive(1'b0, 2'b00, 1'b0);
    checks++; if (maxis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %0b want 0", maxis_tvalid); end
    checks++; if (maxis_tdata !== 8'h00) begin errors++; $display("FAIL reset_tdata got %02h want 00", maxis_tdata); end
    checks++; if (maxis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %0b want 0", maxis_tlast); end
    checks++; if (maxis_tuser !== 1'b0) begin errors++; $display("FAIL reset_tuser got %0b want 0", maxis_tuser); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b want 0", overflow); end
    reset = 1'b0;
    repeat (4) drive(1'b0, 2'b00, 1'b0);
    checks++; if (maxis_tvalid !== 1'b0) begin errors++; $display("FAIL idle_tvalid got %0b want 0", maxis_tvalid); end
  endtask

  task automatic test_known_frames();
    logic [7:0] f[$];
    bit to;
    exp_q.delete(); got_q.delete(); ovf_pulses = 0;
    ready_mode = 1;
    f = '{8'h01, 8'h02, 8'hAB};
    send_frame(f, -1, 0, -1, 4); model_frame(f, 1'b0, 0);
    send_frame(f, 1, 0, -1, 4);  model_frame(f, 1'b1, 0);
    send_frame(f, -1, 1, -1, 4); model_frame(f, 1'b0, 1);
    wait_beats(exp_q.size(), to);
    checks++; if (to || got_q.size() != exp_q.size()) begin errors++; $display("FAIL known_count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL known_beat%0d got data=%02h last=%0b user=%0b want data=%02h last=%0b user=%0b",
                 i, got_q[i].data, got_q[i].last, got_q[i].user, exp_q[i].data, exp_q[i].last, exp_q[i].user);
      end else $display("known beat %0d data=%02h last=%0b user=%0b", i, got_q[i].data, got_q[i].last, got_q[i].user);
    end
    checks++; if (ovf_pulses != 0) begin errors++; $display("FAIL known_overflow got %0d want 0", ovf_pulses); end
  endtask

  task automatic test_overflow();
    logic [7:0] f[$];
    bit to;
    exp_q.delete(); got_q.delete(); ovf_pulses = 0;
    ready_mode = 0;
    for (int i = 0; i < 10; i++) f.push_back(8'($urandom_range(0, 255)));
    send_frame(f, -1, 0, -1, 6);
    for (int i = 0; i < DEPTH; i++) exp_q.push_back('{data: f[i], last: 1'b0, user: 1'b0});
    exp_q.push_back('{data: 8'h00, last: 1'b1, user: 1'b1});
    checks++; if (ovf_pulses != 1) begin errors++; $display("FAIL ovf_pulses got %0d want 1", ovf_pulses); end
    ready_mode = 1;
    wait_beats(exp_q.size(), to);
    checks++; if (to || got_q.size() != exp_q.size()) begin errors++; $display("FAIL ovf_count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL ovf_beat%0d got data=%02h last=%0b user=%0b want data=%02h last=%0b user=%0b",
                 i, got_q[i].data, got_q[i].last, got_q[i].user, exp_q[i].data, exp_q[i].last, exp_q[i].user);
      end else $display("ovf beat %0d data=%02h last=%0b user=%0b", i, got_q[i].data, got_q[i].last, got_q[i].user);
    end
    checks++; if (ovf_pulses != 1) begin errors++; $display("FAIL ovf_pulses_after got %0d want 1", ovf_pulses); end
  endtask

  task automatic test_false_carrier();
    got_q.delete();
    ready_mode = 1;
    repeat (6) drive(1'b1, 2'b00, 1'b0);
    repeat (30) drive(1'b0, 2'b00, 1'b0);
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL false_carrier got %0d beats want 0", got_q.size()); end
    else $display("false carrier: no beats");
  endtask

  task automatic test_reset_midframe();
    logic [7:0] f[$];
    bit to;
    exp_q.delete(); got_q.delete();
    ready_mode = 0;
    f = '{8'h5A, 8'hC3};
    send_frame(f, -1, 0, -1, 0);
    reset = 1'b1;
    repeat (2) drive(1'b0, 2'b00, 1'b0);
    reset = 1'b0;
    repeat (3) drive(1'b0, 2'b00, 1'b0);
    checks++; if (maxis_tvalid !== 1'b0) begin errors++; $display("FAIL midreset_tvalid got %0b want 0", maxis_tvalid); end
    ready_mode = 1;
    f = '{8'h10, 8'h20};
    send_frame(f, -1, 0, -1, 4); model_frame(f, 1'b0, 0);
    wait_beats(exp_q.size(), to);
    checks++; if (to || got_q.size() != exp_q.size()) begin errors++; $display("FAIL midreset_count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL midreset_beat%0d got data=%02h last=%0b user=%0b want data=%02h last=%0b user=%0b",
                 i, got_q[i].data, got_q[i].last, got_q[i].user, exp_q[i].data, exp_q[i].last, exp_q[i].user);
      end else $display("midreset beat %0d data=%02h last=%0b user=%0b", i, got_q[i].data, got_q[i].last, got_q[i].user);
    end
  endtask

  task automatic test_random_frames();
    logic [7:0] f[$];
    int n, er_idx, k, tog;
    bit to;
    exp_q.delete(); got_q.delete(); ovf_pulses = 0;
    ready_mode = 2;
    for (int fr = 0; fr < 8; fr++) begin
      f.delete();
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) f.push_back(8'($urandom_range(0, 255)));
      er_idx = ($urandom_range(0, 9) < 3) ? int'($urandom_range(0, n - 1)) : -1;
      k = $urandom_range(0, 2);
      // A single mid-byte carrier dip must not end the frame or alter data.
      tog = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n - 1)) * 4 + int'($urandom_range(1, 3)) : -1;
      model_frame(f, er_idx >= 0, k);
      send_frame(f, er_idx, k, tog, 3);
    end
    wait_beats(exp_q.size(), to);
    checks++; if (to || got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rand_beat%0d got data=%02h last=%0b user=%0b want data=%02h last=%0b user=%0b",
                 i, got_q[i].data, got_q[i].last, got_q[i].user, exp_q[i].data, exp_q[i].last, exp_q[i].user);
      end else $display("rand beat %0d data=%02h last=%0b user=%0b", i, got_q[i].data, got_q[i].last, got_q[i].user);
    end
    checks++; if (ovf_pulses != 0) begin errors++; $display("FAIL rand_overflow got %0d want 0", ovf_pulses); end
  endtask

  task automatic test_axis_rules();
    checks++;
    if (hold_violations != 0) begin errors++; $display("FAIL axis_hold got %0d violations want 0", hold_violations); end
    else $display("axis hold stability: 0 violations");
  endtask

  initial begin
    test_reset();
    test_known_frames();
    test_overflow();
    test_false_carrier();
    test_reset_midframe();
    test_random_frames();
    test_axis_rules();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
